divider_32_bit: RTL and testbench

DIVIDER_32_BIT -- requirements
Module: divider_32_bit

---
 rtl/divider_32_bit.sv | 171 +++++++++++++++++
 tb/tb_divider_32_bit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/divider_32_bit.sv
// Sequential restoring divider, 32-bit, fixed 34-cycle start-to-done latency.
// Ports: clock, clear_n (async low reset), start/signed_op/dividend/divisor in;
//   busy, done, quotient, remainder, div_by_zero out.
// Optional macro DIVIDER_SIGNED_EN enables two's-complement operation.
module divider_32_bit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] dvnd_q, dvnd_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_by_zero_q, div_by_zero_d;

    logic             sgn_op;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   sh, trial;

    always_comb begin
`ifdef DIVIDER_SIGNED_EN
        sgn_op = signed_op;
`else
        // signed_op has no effect in the unsigned-only build
        sgn_op = signed_op & 1'b0;
`endif
        a_neg = sgn_op & dividend[WIDTH-1];
        b_neg = sgn_op & divisor[WIDTH-1];
        a_mag = a_neg ? ('0 - dividend) : dividend;
        b_mag = b_neg ? ('0 - divisor) : divisor;

        // one restoring step: shift {rem,quo} left, 33-bit trial subtract
        sh    = {rem_q, quo_q[WIDTH-1]};
        trial = sh - {1'b0, dvsr_q};

        state_d       = state_q;
        cnt_d         = cnt_q;
        rem_d         = rem_q;
        quo_d         = quo_q;
        dvsr_d        = dvsr_q;
        dvnd_d        = dvnd_q;
        qneg_d        = qneg_q;
        rneg_d        = rneg_q;
        zero_d        = zero_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    cnt_d   = 5'd31;
                    rem_d   = '0;
                    quo_d   = a_mag;
                    dvsr_d  = b_mag;
                    dvnd_d  = dividend;
                    qneg_d  = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    zero_d  = (divisor == '0);
                end
            end
            RUN: begin
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = sh[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == 5'd0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            FIX: begin
                state_d = DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (zero_q) begin
                    // divide by zero reports the raw dividend bits
                    quotient_d    = '1;
                    remainder_d   = dvnd_q;
                    div_by_zero_d = 1'b1;
                end else begin
                    quotient_d    = qneg_q ? ('0 - quo_q) : quo_q;
                    remainder_d   = rneg_q ? ('0 - rem_q) : rem_q;
                    div_by_zero_d = 1'b0;
                end
            end
            DONE: begin
                // start is not sampled here; accepted next cycle in IDLE
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            dvsr_q        <= '0;
            dvnd_q        <= '0;
            qneg_q        <= 1'b0;
            rneg_q        <= 1'b0;
            zero_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rem_q         <= rem_d;
            quo_q         <= quo_d;
            dvsr_q        <= dvsr_d;
            dvnd_q        <= dvnd_d;
            qneg_q        <= qneg_d;
            rneg_q        <= rneg_d;
            zero_q        <= zero_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_divider_32_bit.sv
// Bench for divider_32_bit: cycle-timeline model plus arithmetic reference.
// Directed literal cases followed by randomized back-to-back traffic.
module tb_divider_32_bit;

    logic        clock = 1'b0;
    logic        clear_n = 1'b0;
    logic        start = 1'b0;
    logic        signed_op = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] quotient, remainder;

    divider_32_bit #(.WIDTH(32)) dut (
        .clock       (clock),
        .clear_n     (clear_n),
        .start       (start),
        .signed_op   (signed_op),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clock = ~clock;

`ifdef DIVIDER_SIGNED_EN
    localparam bit SGN_EN = 1'b1;
`else
    localparam bit SGN_EN = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;

    // model: cycles since accepted start (-1 idle), pending and held results
    int          cnt = -1;
    logic [31:0] pq, pr, hq, hr;
    logic        pz, hz;

    function automatic void model_div(input logic [31:0] a, input logic [31:0] b,
                                      input logic s, output logic [31:0] q,
                                      output logic [31:0] r, output logic z);
        longint sa, sb, lq, lr;
        z = (b == 32'd0);
        if (z) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s && SGN_EN) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[31:0];
            r  = lr[31:0];
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // advance one clock; update the model, then compare every output
    task automatic tick();
        @(posedge clock);
        if (!clear_n) begin
            cnt = -1;
            hq = '0; hr = '0; hz = 1'b0;
        end else if (cnt < 0) begin
            if (start) begin
                model_div(dividend, divisor, signed_op, pq, pr, pz);
                cnt = 1;
            end
        end else if (cnt == 34) begin
            hq = pq; hr = pr; hz = pz;
            cnt = -1;
        end else begin
            cnt++;
        end
        #1;
        chk1("busy", busy, (cnt >= 1) && (cnt <= 33));
        chk1("done", done, cnt == 34);
        if (cnt == 34) begin
            chk("quotient", quotient, pq);
            chk("remainder", remainder, pr);
            chk1("div_by_zero", div_by_zero, pz);
        end else if (cnt < 0) begin
            chk("held_quotient", quotient, hq);
            chk("held_remainder", remainder, hr);
            chk1("held_div_by_zero", div_by_zero, hz);
        end
    endtask

    task automatic wait_done(input string nm, input int from);
        int n;
        n = from;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        chk({nm, "_latency"}, 32'(n), 32'd34);
    endtask

    task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] lq, input logic [31:0] lr,
                          input logic lz);
        dividend = a; divisor = b; signed_op = s; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(nm, 1);
        chk({nm, "_q"}, quotient, lq);
        chk({nm, "_r"}, remainder, lr);
        chk1({nm, "_z"}, div_by_zero, lz);
        tick();
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2;
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_done", done, 1'b0);
        chk("reset_q", quotient, 32'd0);
        chk("reset_r", remainder, 32'd0);
        chk1("reset_z", div_by_zero, 1'b0);
        tick();
        tick();
        clear_n = 1'b1;
        tick();

        run_op("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
`ifdef DIVIDER_SIGNED_EN
        run_op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run_op("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0);
`else
        run_op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 1'b0);
        run_op("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 1'b0);
`endif
        run_op("u5_0", 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1);
        run_op("s_m7_0", 32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1);
        run_op("umax_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0);

        // start while busy is ignored
        dividend = 32'd50; divisor = 32'd5; signed_op = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 9; i++) tick();
        dividend = 32'd9; divisor = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("busy_ign", 10);
        chk("busy_ign_q", quotient, 32'd10);
        chk("busy_ign_r", remainder, 32'd0);

        // start held through the DONE cycle is taken one cycle later
        dividend = 32'd77; divisor = 32'd7; start = 1'b1;
        tick();
        chk1("done_start_ignored", busy, 1'b0);
        tick();
        chk1("done_start_taken", busy, 1'b1);
        start = 1'b0;
        wait_done("after_done", 1);
        chk("after_done_q", quotient, 32'd11);
        tick();

        // reset mid-operation aborts with no done pulse
        dividend = 32'd20; divisor = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 5; i++) tick();
        clear_n = 1'b0;
        #2;
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_done", done, 1'b0);
        chk("abort_q", quotient, 32'd0);
        chk("abort_r", remainder, 32'd0);
        chk1("abort_z", div_by_zero, 1'b0);
        tick();
        clear_n = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        run_op("fresh", 32'd20, 32'd3, 1'b0, 32'd6, 32'd2, 1'b0);

        // random traffic, start asserted often including back-to-back
        for (int i = 0; i < 3000; i++) begin
            start     = ($urandom_range(0, 2) != 0);
            signed_op = $urandom_range(0, 1) != 0;
            dividend  = rnd_op();
            divisor   = rnd_op();
            tick();
        end
        start = 1'b0;
        for (int i = 0; i < 40; i++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
